// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, fetches over an imem req/ack handshake, loads the IF/ID
// register (pc_o = fetched PC + 4, inst_o = instruction) and inserts NOP
// bubbles whenever no instruction is ready while the pipeline advances.
// Optional build macro IF_FLUSH_EN: a taken jump/branch squashes the slot
// instruction. Without it, MIPS branch-delay-slot semantics apply: the slot
// instruction is delivered and only its successor comes from the target.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        Stall_i,
  input  logic        mem_stall_i,
  input  logic        Jump_i,
  input  logic        Branch_i,
  input  logic        Eq_i,
  input  logic [31:0] JumpPC_i,
  input  logic [31:0] BranchPC_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_q, buf_d;

  logic        adv;
  logic        taken;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  // Pipeline advance, accepted redirect and next-PC selection
  always_comb begin
    adv      = start_i & ~Stall_i & ~mem_stall_i;
    taken    = adv & (Jump_i | (Branch_i & Eq_i));
    target   = Jump_i ? JumpPC_i : BranchPC_i;
    pc_plus4 = pc_q + 32'd4;
    // A redirect arriving this cycle beats an older pending one
    if (taken)       next_pc = target;
    else if (pend_q) next_pc = tgt_q;
    else             next_pc = pc_plus4;
  end

  // Fetch FSM: next-state, PC, IF/ID, redirect bookkeeping
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_pc_d   = ifid_pc_q;
    ifid_inst_d = ifid_inst_q;
    pend_d      = pend_q;
    tgt_d       = tgt_q;
    buf_d       = buf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (imem_ack_i) begin
          if (adv) begin
`ifdef IF_FLUSH_EN
            if (taken) begin
              // Squashed slot: bubble keeps the previous pc_o
              ifid_inst_d = NOP_INST;
            end else begin
              ifid_pc_d   = pc_plus4;
              ifid_inst_d = imem_data_i;
            end
`else
            ifid_pc_d   = pc_plus4;
            ifid_inst_d = imem_data_i;
`endif
            pc_d   = next_pc;
            pend_d = 1'b0;
          end else begin
            // Pipeline frozen: park the instruction until it can advance
            buf_d   = imem_data_i;
            state_d = S_HOLD;
          end
        end else if (adv) begin
          ifid_inst_d = NOP_INST;
          if (taken) begin
            tgt_d = target;
`ifdef IF_FLUSH_EN
            // Request is in flight; its data must be thrown away
            state_d = S_DROP;
`else
            // Slot instruction still coming; its successor uses the target
            pend_d = 1'b1;
`endif
          end
        end
      end

      S_HOLD: begin
        if (adv) begin
`ifdef IF_FLUSH_EN
          if (taken) begin
            ifid_inst_d = NOP_INST;
          end else begin
            ifid_pc_d   = pc_plus4;
            ifid_inst_d = buf_q;
          end
`else
          ifid_pc_d   = pc_plus4;
          ifid_inst_d = buf_q;
`endif
          pc_d    = next_pc;
          pend_d  = 1'b0;
          state_d = S_FETCH;
        end
      end

      S_DROP: begin
        if (adv) ifid_inst_d = NOP_INST;
        if (taken) tgt_d = target;
        if (imem_ack_i) begin
          // Discarded ack closes the stale request; move to the target even
          // if stalled, since only the fetch address (not IF/ID) changes
          pc_d    = taken ? target : tgt_q;
          state_d = start_i ? S_FETCH : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_FETCH) || (state_d == S_DROP);
  end

  // State and output registers; reset abandons any outstanding request
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_q       <= 1'b0;
      ifid_pc_q   <= 32'h0000_0000;
      ifid_inst_q <= 32'h0000_0000;
      pend_q      <= 1'b0;
      tgt_q       <= 32'h0000_0000;
      buf_q       <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_q       <= req_d;
      ifid_pc_q   <= ifid_pc_d;
      ifid_inst_q <= ifid_inst_d;
      pend_q      <= pend_d;
      tgt_q       <= tgt_d;
      buf_q       <= buf_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = pc_q;
  assign pc_o        = ifid_pc_q;
  assign inst_o      = ifid_inst_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Instruction memory returns 32'hA000_0000 | addr
// after a programmable number of no-ack request cycles.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        mstall;
  logic        jump;
  logic        branch;
  logic        eq;
  logic [31:0] jpc;
  logic [31:0] bpc;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int wait_n;
  int cnt;
  int n_vec;
  int n_err;

  if_stage #(
    .RESET_PC(32'h0000_0000),
    .NOP_INST(32'h0000_0000)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .start_i    (start),
    .Stall_i    (stall),
    .mem_stall_i(mstall),
    .Jump_i     (jump),
    .Branch_i   (branch),
    .Eq_i       (eq),
    .JumpPC_i   (jpc),
    .BranchPC_i (bpc),
    .imem_req_o (req),
    .imem_addr_o(addr),
    .imem_ack_i (ack),
    .imem_data_i(data),
    .pc_o       (pc_o),
    .inst_o     (inst_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack once the request has waited wait_n cycles
  assign ack  = req && (cnt == wait_n);
  assign data = 32'hA000_0000 | addr;

  always @(posedge clk) begin
    if (!rst_n || !req || ack) cnt <= 0;
    else                       cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    wait_n = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    stall  = 1'b0;
    mstall = 1'b0;
    jump   = 1'b0;
    branch = 1'b0;
    eq     = 1'b0;
    jpc    = 32'h0;
    bpc    = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_pc_o", pc_o, 32'h0);
    chk("rst_inst_o", inst_o, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);

    // Zero-wait sequential fetch
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("start_req", {31'b0, req}, 32'h1);
    chk("start_addr", addr, 32'h0);
    chk("start_inst_o", inst_o, 32'h0);
    @(negedge clk);
    chk("seq0_pc", pc_o, 32'h4);
    chk("seq0_inst", inst_o, 32'hA000_0000);
    @(negedge clk);
    chk("seq1_pc", pc_o, 32'h8);
    chk("seq1_inst", inst_o, 32'hA000_0004);
    @(negedge clk);
    chk("seq2_pc", pc_o, 32'hC);
    chk("seq2_inst", inst_o, 32'hA000_0008);

    // Ack after two empty cycles: two bubbles, address held
    wait_n = 2;
    @(negedge clk);
    chk("lat_nop1_inst", inst_o, 32'h0);
    chk("lat_nop1_pc", pc_o, 32'hC);
    chk("lat_nop1_addr", addr, 32'hC);
    @(negedge clk);
    chk("lat_nop2_inst", inst_o, 32'h0);
    chk("lat_nop2_addr", addr, 32'hC);
    @(negedge clk);
    chk("lat_pc", pc_o, 32'h10);
    chk("lat_inst", inst_o, 32'hA000_000C);

    // Hazard stall for two cycles, ack arrives mid-stall
    wait_n = 1;
    stall  = 1'b1;
    @(negedge clk);
    chk("stl1_pc", pc_o, 32'h10);
    chk("stl1_inst", inst_o, 32'hA000_000C);
    @(negedge clk);
    chk("stl2_pc", pc_o, 32'h10);
    chk("stl2_inst", inst_o, 32'hA000_000C);
    chk("stl2_hold_req", {31'b0, req}, 32'h0);
    stall  = 1'b0;
    wait_n = 0;
    @(negedge clk);
    chk("stl_rel_pc", pc_o, 32'h14);
    chk("stl_rel_inst", inst_o, 32'hA000_0010);
    @(negedge clk);
    chk("stl_next_pc", pc_o, 32'h18);
    chk("stl_next_inst", inst_o, 32'hA000_0014);

    // Jump to 0x40 with ack in the same cycle (slot at 0x18)
    jump = 1'b1;
    jpc  = 32'h40;
    @(negedge clk);
    jump = 1'b0;
`ifdef IF_FLUSH_EN
    chk("jmp_slot_inst", inst_o, 32'h0);
    chk("jmp_slot_pc", pc_o, 32'h18);
`else
    chk("jmp_slot_inst", inst_o, 32'hA000_0018);
    chk("jmp_slot_pc", pc_o, 32'h1C);
`endif
    chk("jmp_addr", addr, 32'h40);
    @(negedge clk);
    chk("jmp_tgt_pc", pc_o, 32'h44);
    chk("jmp_tgt_inst", inst_o, 32'hA000_0040);

    // Branch not taken: sequential fetch continues
    branch = 1'b1;
    eq     = 1'b0;
    bpc    = 32'h80;
    @(negedge clk);
    branch = 1'b0;
    chk("bnt_pc", pc_o, 32'h48);
    chk("bnt_inst", inst_o, 32'hA000_0044);

    // Branch taken to 0x100 while fetch of 0x48 waits two cycles
    wait_n = 2;
    branch = 1'b1;
    eq     = 1'b1;
    bpc    = 32'h100;
    @(negedge clk);
    branch = 1'b0;
    eq     = 1'b0;
    chk("bpend1_inst", inst_o, 32'h0);
    chk("bpend1_addr", addr, 32'h48);
    @(negedge clk);
    chk("bpend2_inst", inst_o, 32'h0);
    chk("bpend2_addr", addr, 32'h48);
    @(negedge clk);
`ifdef IF_FLUSH_EN
    chk("bslot_inst", inst_o, 32'h0);
    chk("bslot_pc", pc_o, 32'h48);
`else
    chk("bslot_inst", inst_o, 32'hA000_0048);
    chk("bslot_pc", pc_o, 32'h4C);
`endif
    chk("btgt_addr", addr, 32'h100);
    wait_n = 0;
    @(negedge clk);
    chk("btgt_pc", pc_o, 32'h104);
    chk("btgt_inst", inst_o, 32'hA000_0100);

    // Data-memory stall freezes IF/ID and PC
    mstall = 1'b1;
    @(negedge clk);
    chk("mst_pc", pc_o, 32'h104);
    chk("mst_inst", inst_o, 32'hA000_0100);
    mstall = 1'b0;
    @(negedge clk);
    chk("mst_rel_pc", pc_o, 32'h108);
    chk("mst_rel_inst", inst_o, 32'hA000_0104);

    // Reset while a request is outstanding
    wait_n = 3;
    @(negedge clk);
    chk("prerst_req", {31'b0, req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, req}, 32'h0);
    chk("arst_addr", addr, 32'h0);
    chk("arst_pc", pc_o, 32'h0);
    chk("arst_inst", inst_o, 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    wait_n = 0;
    @(negedge clk);
    chk("restart_addr", addr, 32'h0);
    @(negedge clk);
    chk("restart_pc", pc_o, 32'h4);
    chk("restart_inst", inst_o, 32'hA000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC, fetches from instruction memory over a req/ack handshake, and loads the IF/ID register consumed by the decode stage. It consumes decode's jump/branch redirect (Jump, Branch, Eq, JumpPC, BranchPC), honours hazard and data-memory stalls, and injects NOP bubbles when no instruction is ready.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset
- NOP_INST, 32'h0000_0000, bubble instruction (sll $0,$0,0)

Ports (reset is asynchronous, active-low):
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  pipeline run enable
- Stall_i  in  1  load-use hazard stall from hazard unit
- mem_stall_i  in  1  data-memory stall (freezes whole pipeline)
- Jump_i  in  1  jump from decode
- Branch_i  in  1  branch instruction in decode
- Eq_i  in  1  branch condition true
- JumpPC_i  in  32  jump target
- BranchPC_i  in  32  branch target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address (current PC)
- imem_ack_i  in  1  instruction valid on imem_data_i
- imem_data_i  in  32  fetched instruction
- pc_o  out  32  IF/ID: fetched PC + 4
- inst_o  out  32  IF/ID: instruction

## Operation
- adv = start_i & ~Stall_i & ~mem_stall_i; IF/ID and PC update only when adv.
- taken = Jump_i | (Branch_i & Eq_i); accepted only when adv. Target = Jump_i ? JumpPC_i : BranchPC_i (jump wins).
- States: IDLE, FETCH, HOLD, DROP.
- IDLE: req=0. start_i=1 -> FETCH.
- FETCH: req=1, addr=PC. On ack & adv: IF/ID <= {PC+4, data}, PC <= next. On ack & ~adv: data into hold buffer -> HOLD. No ack & adv: IF/ID <= {PC+4-of-previous (unchanged pc_o), NOP_INST}.
- HOLD: req=0. On adv: IF/ID <= {PC+4, buffer}, PC <= next -> FETCH.
- DROP: req=1 on the same address until ack; ack data discarded; IF/ID <= NOP while adv; then -> FETCH at redirected PC.
- next = redirect_pending ? target_reg : PC+4; redirect_pending/target_reg set on accepted taken, cleared when used.
- Accepted taken redirect, by state (see Configuration): current slot instruction either squashed or delivered; PC then loads target.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 0; bits [1:0] passed through unchecked.
- Reset mid-fetch: outstanding request abandoned; memory must tolerate req dropping without ack.

## Timing
- Reset: PC=RESET_PC, pc_o=0, inst_o=0, imem_req_o=0, imem_addr_o=RESET_PC, state IDLE, redirect_pending=0, hold buffer=0.
- imem_addr_o stable while req=1 and ack=0. Ack may arrive same cycle as req (zero-wait).
- Zero-wait memory, no stalls: one instruction into IF/ID per cycle; first valid inst_o one cycle after start_i rises plus ack latency.
- Stall_i or mem_stall_i: pc_o/inst_o hold exactly; PC holds.
- Redirect and ack same cycle: handled as ack-then-redirect (slot instruction is the acked one).
- start_i low: no new request issued; outstanding request completes into HOLD.

## Configuration
- IF_FLUSH_EN defined: taken redirect squashes the slot instruction. FETCH+ack -> IF/ID <= NOP, PC <= target. FETCH no-ack -> DROP, PC <= target after discarded ack. HOLD -> buffer discarded, PC <= target, -> FETCH.
- IF_FLUSH_EN undefined: MIPS branch-delay-slot semantics. Slot instruction delivered normally to IF/ID; redirect_pending makes its successor fetch from target. DROP state unused.

## Test plan
- Zero-wait ack, start_i=1 from reset: inst_o sequence matches mem[0],mem[4],mem[8]; pc_o = 4,8,12 on consecutive cycles.
- Ack latency 3 cycles: inst_o = NOP for 2 cycles between valid instructions; imem_addr_o constant during wait.
- Stall_i for 2 cycles with ack arriving mid-stall: state HOLD, pc_o/inst_o frozen, instruction delivered on release, none lost/duplicated.
- Jump_i=1, JumpPC_i=32'h40 with IF_FLUSH_EN: slot instruction replaced by NOP, next valid inst_o = mem[0x40], pc_o=0x44; without: slot delivered, then mem[0x40].
- Branch_i=1, Eq_i=0: no redirect; sequential fetch continues. Branch_i=1, Eq_i=1 during pending ack (IF_FLUSH_EN): DROP, late ack discarded, then target fetched.
- rst_i low while req outstanding: all outputs at reset values immediately; fetch restarts at RESET_PC after rst_i high and start_i=1.
